// File: rtl/seq_bcd_splitter.sv
// Sequential binary-to-BCD converter using iterative shift-add-3, one input bit per cycle.
// Optional leading-zero blanking output is compiled in when BCD_BLANK_EN is defined.
module seq_bcd_splitter #(
    parameter int IN_W   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digit,
    output logic                  overflow
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    logic [IN_W-1:0]    bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_acc_r;

    logic [BCD_W-1:0]   bcd_adj_s;
    logic [BCD_W-1:0]   bcd_next_s;
    logic               carry_s;
    logic               last_shift_s;

    // Add 3 to every nibble that is 5 or more so the following doubling carries in decimal.
    function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

`ifdef BCD_BLANK_EN
    // Digit k is blank when it and every higher digit are zero; the ones digit is never blank.
    function automatic logic [DIGITS-1:0] blank_of(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] b;
        logic              zero_above;
        b          = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (v[4*k +: 4] == 4'd0);
            b[k]       = zero_above;
        end
        return b;
    endfunction
`endif

    // Next working register value for one shift step; the top bit falling out feeds overflow.
    always_comb begin
        bcd_adj_s    = add3_nibbles(bcd_r);
        bcd_next_s   = {bcd_adj_s[BCD_W-2:0], bin_r[IN_W-1]};
        carry_s      = bcd_adj_s[BCD_W-1];
        last_shift_s = (cnt_r == CNT_W'(1));
    end

    // Control FSM, working datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bin_r     <= '0;
            bcd_r     <= '0;
            cnt_r     <= '0;
            ovf_acc_r <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            digit     <= '0;
            overflow  <= 1'b0;
`ifdef BCD_BLANK_EN
            blank     <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r   <= SHIFT;
                        bin_r     <= bin;
                        bcd_r     <= '0;
                        cnt_r     <= CNT_W'(IN_W);
                        ovf_acc_r <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                SHIFT: begin
                    bcd_r     <= bcd_next_s;
                    bin_r     <= {bin_r[IN_W-2:0], 1'b0};
                    cnt_r     <= cnt_r - CNT_W'(1);
                    ovf_acc_r <= ovf_acc_r | carry_s;
                    busy      <= 1'b1;
                    if (last_shift_s) begin
                        state_r  <= DONE;
                        done     <= 1'b1;
                        digit    <= bcd_next_s;
                        overflow <= ovf_acc_r | carry_s;
`ifdef BCD_BLANK_EN
                        blank    <= blank_of(bcd_next_s);
`endif
                    end else begin
                        done     <= 1'b0;
                    end
                end
                DONE: begin
                    // start is deliberately ignored here; a held start is taken in the next IDLE cycle
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bcd_splitter.sv
// Directed self-checking bench for seq_bcd_splitter at default parameters.
// Checks blank as well when BCD_BLANK_EN is defined.
module tb_seq_bcd_splitter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] digit;
    logic        overflow;
`ifdef BCD_BLANK_EN
    logic [3:0]  blank;
`endif

    int checks;
    int errors;

    seq_bcd_splitter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .digit    (digit),
        .overflow (overflow)
`ifdef BCD_BLANK_EN
        ,
        .blank    (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] b;
        logic [15:0] d;
        logic        o;
        logic [3:0]  bl;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; returns the cycle done was seen and how many cycles busy was high.
    task automatic do_conv(input logic [13:0] b, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        start    = 1'b1;
        bin      = b;
        tick();
        start    = 1'b0;
        bin      = ~b;
        lat      = 1;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        if (busy) busy_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          bcnt;
        int          dcount;
        int          dcyc[2];
        logic [15:0] dval[2];
        logic [15:0] held;

        checks = 0;
        errors = 0;
        vecs[0]  = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
        vecs[1]  = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
        vecs[2]  = '{14'd16383, 16'h6383, 1'b1, 4'b0000};
        vecs[3]  = '{14'd0,     16'h0000, 1'b0, 4'b1110};
        vecs[4]  = '{14'd5,     16'h0005, 1'b0, 4'b1110};
        vecs[5]  = '{14'd10000, 16'h0000, 1'b1, 4'b1110};
        vecs[6]  = '{14'd1,     16'h0001, 1'b0, 4'b1110};
        vecs[7]  = '{14'd8191,  16'h8191, 1'b0, 4'b0000};
        vecs[8]  = '{14'd10001, 16'h0001, 1'b1, 4'b1110};
        vecs[9]  = '{14'd4096,  16'h4096, 1'b0, 4'b0000};
        vecs[10] = '{14'd7,     16'h0007, 1'b0, 4'b1110};
        vecs[11] = '{14'd1005,  16'h1005, 1'b0, 4'b0000};
        vecs[12] = '{14'd42,    16'h0042, 1'b0, 4'b1100};

        reset = 1'b1;
        start = 1'b0;
        bin   = 14'd0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_digit", {16'b0, digit}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
`ifdef BCD_BLANK_EN
        check("rst_blank", {28'b0, blank}, 32'd0);
`endif
        reset = 1'b0;

        // First vector starts in the very first cycle after reset release.
        for (int i = 0; i < 13; i++) begin
            do_conv(vecs[i].b, lat, bcnt);
            check("latency", lat, 32'd15);
            check("busy_cycles", bcnt, 32'd15);
            check("digit", {16'b0, digit}, {16'b0, vecs[i].d});
            check("overflow", {31'b0, overflow}, {31'b0, vecs[i].o});
`ifdef BCD_BLANK_EN
            check("blank", {28'b0, blank}, {28'b0, vecs[i].bl});
`endif
            held = digit;
            tick();
            check("idle_busy", {31'b0, busy}, 32'd0);
            check("idle_done", {31'b0, done}, 32'd0);
            tick();
            tick();
            check("hold_digit", {16'b0, digit}, {16'b0, held});
        end

        // start and bin disturbed at cycle 3 and in the DONE cycle: single 1234 result only.
        dcount = 0;
        dcyc[0] = 0;
        dval[0] = 16'h0;
        start = 1'b1;
        bin   = 14'd1234;
        tick();
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                if (dcount == 0) begin
                    dcyc[0] = c;
                    dval[0] = digit;
                end
                dcount++;
            end
            start = (c == 3 || c == 15);
            bin   = 14'd42;
            tick();
        end
        start = 1'b0;
        check("ign_done_count", dcount, 32'd1);
        check("ign_done_cycle", dcyc[0], 32'd15);
        check("ign_digit", {16'b0, dval[0]}, 32'h1234);
        check("ign_busy_after", {31'b0, busy}, 32'd0);

        // Reset asserted at cycle 7 aborts without a done pulse.
        do_conv(14'd9876, lat, bcnt);
        check("pre_abort_digit", {16'b0, digit}, 32'h9876);
        tick();
        dcount = 0;
        start = 1'b1;
        bin   = 14'd1234;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) begin
            if (done) dcount++;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_digit", {16'b0, digit}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        for (int c = 0; c < 20; c++) begin
            if (done) dcount++;
            tick();
        end
        check("abort_no_done", dcount, 32'd0);
        do_conv(14'd42, lat, bcnt);
        check("post_abort_lat", lat, 32'd15);
        check("post_abort_digit", {16'b0, digit}, 32'h0042);
        tick();

        // start held high: back-to-back conversions of 0 then 5, results 16 cycles apart.
        dcount = 0;
        dcyc[0] = 0;
        dcyc[1] = 0;
        dval[0] = 16'hffff;
        dval[1] = 16'hffff;
        start = 1'b1;
        bin   = 14'd0;
        tick();
        bin   = 14'd5;
        for (int c = 1; c <= 45; c++) begin
            if (done) begin
                if (dcount < 2) begin
                    dcyc[dcount] = c;
                    dval[dcount] = digit;
                end
                dcount++;
            end
            if (c >= 17) start = 1'b0;
            tick();
        end
        check("b2b_count", dcount, 32'd2);
        check("b2b_first_cycle", dcyc[0], 32'd15);
        check("b2b_spacing", dcyc[1] - dcyc[0], 32'd16);
        check("b2b_first_digit", {16'b0, dval[0]}, 32'h0000);
        check("b2b_second_digit", {16'b0, dval[1]}, 32'h0005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_bcd_splitter.md
SEQ_BCD_SPLITTER -- requirements
Module: seq_bcd_splitter

Interface
REQ-001 Parameter IN_W, default 14, width of the binary input in bits (legal range 4..32).
REQ-002 Parameter DIGITS, default 4, number of BCD digits produced (legal range 1..10).
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-005 Port start, input, 1, conversion request, sampled on each clk rising edge.
REQ-006 Port bin, input, IN_W, binary value to convert, captured in the cycle start is accepted.
REQ-007 Port busy, output, 1, high while a conversion is in progress.
REQ-008 Port done, output, 1, one-cycle pulse marking that digit and overflow have been updated.
REQ-009 Port digit, output, 4*DIGITS, packed BCD result; bits [3:0] are the ones digit and bits [4k+3:4k] are digit 10^k.
REQ-010 Port overflow, output, 1, high when the last accepted bin was >= 10^DIGITS.

Function
REQ-011 Conversion SHALL use iterative shift-add-3 (double dabble), one input bit per clk cycle, MSB first, with no divide or modulo operators.
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE->SHIFT when start=1; bin SHALL be latched, the working BCD register cleared, the bit counter loaded with IN_W, and the overflow accumulator cleared.
REQ-014 In SHIFT, each cycle: every working nibble >= 5 gets +3, then the register shifts left one bit with the next bin bit entering at the LSB, and the counter decrements.
REQ-015 SHIFT->DONE after exactly IN_W shift cycles; DONE->IDLE unconditionally on the next cycle.
REQ-016 digit and overflow SHALL be registered and SHALL update only on entry to DONE; they SHALL hold their values between conversions.
REQ-017 done SHALL be high only in DONE, exactly IN_W+1 cycles after the cycle in which start was accepted.
REQ-018 busy SHALL be high in SHIFT and DONE and low in IDLE.
REQ-019 start SHALL be ignored while busy=1, including in the DONE cycle; bin changes while busy SHALL NOT affect the result.
REQ-020 A bit shifted out of the top digit SHALL set the overflow accumulator (sticky OR); digit then holds bin mod 10^DIGITS.
REQ-021 bin=0 SHALL yield all-zero digits and overflow=0 with normal latency.
REQ-022 Back-to-back conversions: start held high SHALL start a new conversion in the first IDLE cycle after DONE, giving one result every IN_W+2 cycles.

Reset
REQ-023 While reset=1, the FSM SHALL enter IDLE and busy, done, overflow and digit SHALL be 0 on the next edge.
REQ-024 reset takes priority over start; a reset during SHIFT or DONE SHALL abort the conversion without any done pulse.
REQ-025 A start applied in the first cycle after reset is released SHALL be accepted.

Configuration
REQ-026 When macro BCD_BLANK_EN is defined, the module SHALL have an extra output blank[DIGITS-1:0], registered with digit, where blank[k]=1 iff digit k and every higher digit are zero, for k >= 1; blank[0] SHALL always be 0 and blank SHALL reset to 0.
REQ-027 When BCD_BLANK_EN is undefined, blank and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Defaults, bin=1234, one-cycle start -> done 15 cycles later, digit=16'h1234, overflow=0, busy high for 15 cycles.
REQ-029 bin=9999 -> digit=16'h9999, overflow=0; then bin=16383 -> digit=16'h6383, overflow=1.
REQ-030 start pulsed and bin changed to 42 at cycles 3 and 15 of a 1234 conversion -> result 16'h1234 only, a single done pulse, no second conversion.
REQ-031 reset=1 at cycle 7 of a conversion -> next cycle busy=0 and digit=0, no done pulse; a fresh start then converts correctly.
REQ-032 start held high for bin=0 then bin=5 -> done pulses 16 cycles apart with results 16'h0000 then 16'h0005.
REQ-033 With BCD_BLANK_EN, bin=7 -> blank=4'b1110; bin=1005 -> blank=4'b0000; bin=0 -> blank=4'b1110.
